// File: rtl/counter_cmd_sched.sv
// rtl/counter_cmd_sched.sv - queues button presses and presents one step/hold command per counter tick window
module counter_cmd_sched #(
  parameter int TICK_DIV = 50000000,
  parameter int QDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                btn_step,
  input  logic [1:0]                btn_hold,
  input  logic                      flush,
  output logic [3:0]                step_option,
  output logic [2:0]                hold_option,
  output logic                      tick,
  output logic [$clog2(QDEPTH):0]   q_level,
  output logic                      overflow,
  output logic                      busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(QDEPTH);

  logic [DW-1:0] div_cnt;
  logic [5:0]    armed;
  logic [5:0]    edges;
  logic          multi_edge;
  logic          press_valid;
  logic [2:0]    press_code;
  logic [2:0]    mem [QDEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [2:0]    head;
  logic [2:0]    pres;
  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;
  logic          drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // armed[i] means the button was low last cycle; clearing it on reset keeps a held button from counting as a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= '0;
    else          armed <= ~{btn_hold, btn_step};
  end

  assign edges       = {btn_hold, btn_step} & armed;
  assign multi_edge  = |(edges & (edges - 6'd1));
  assign press_valid = |edges;

  always_comb begin
    press_code = 3'd0;
    if      (edges[4]) press_code = 3'd5;
    else if (edges[5]) press_code = 3'd6;
    else if (edges[0]) press_code = 3'd1;
    else if (edges[1]) press_code = 3'd2;
    else if (edges[2]) press_code = 3'd3;
    else if (edges[3]) press_code = 3'd4;
  end

  assign q_level = wr_ptr - rd_ptr;
  assign full    = (q_level == LVL_FULL);
  assign empty   = (q_level == '0);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign deq     = tick & ~empty & ~flush;
  assign enq     = press_valid & (~full | deq) & ~flush;
  assign drop    = ~flush & ((press_valid & full & ~deq) | multi_edge);

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[AW-1:0]] <= press_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pres     <= 3'd0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pres     <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (enq)  wr_ptr   <= wr_ptr + 1'b1;
      if (deq)  rd_ptr   <= rd_ptr + 1'b1;
      if (tick) pres     <= empty ? 3'd0 : head;
      if (drop) overflow <= 1'b1;
    end
  end

  // Step and hold decode from one code, so they can never be driven together
  always_comb begin
    step_option = 4'b0000;
    hold_option = 3'b000;
    case (pres)
      3'd1: step_option = 4'b0001;
      3'd2: step_option = 4'b0010;
      3'd3: step_option = 4'b0100;
      3'd4: step_option = 4'b1000;
      3'd5: hold_option = 3'b001;
      3'd6: hold_option = 3'b010;
      default: ;
    endcase
  end

  assign busy = (pres != 3'd0) | (q_level != '0);

endmodule

// File: tb/tb_counter_cmd_sched.sv
// tb/tb_counter_cmd_sched.sv - directed self-checking bench for counter_cmd_sched
module tb_counter_cmd_sched;

  logic       clk;
  logic       reset_n;
  logic [3:0] btn_step;
  logic [1:0] btn_hold;
  logic       flush;
  logic [3:0] step_option;
  logic [2:0] hold_option;
  logic       tick;
  logic [2:0] q_level;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc;

  counter_cmd_sched #(.TICK_DIV(8), .QDEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_step(btn_step), .btn_hold(btn_hold), .flush(flush),
    .step_option(step_option), .hold_option(hold_option), .tick(tick), .q_level(q_level),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] s, input logic [1:0] h);
    btn_step = s;
    btn_hold = h;
    clk1();
    btn_step = 4'b0;
    btn_hold = 2'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    clk1();
    flush = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      clk1();
      n++;
    end while (tick !== 1'b1 && n < 20);
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    btn_step = 4'b0001;
    btn_hold = 2'b00;
    flush    = 1'b0;
    repeat (3) clk1();
    total++;
    if ({tick, step_option, hold_option, q_level, overflow, busy} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {tick, step_option, hold_option, q_level, overflow, busy});
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      clk1();
      total++;
      if (tick !== (k % 8 == 0)) begin
        bad++;
        $display("FAIL reset_tick_phase: cycle %0d tick=%b required %b", k, tick, (k % 8 == 0));
      end
      total++;
      if (q_level !== 3'd0 || busy !== 1'b0 || step_option !== 4'b0) begin
        bad++;
        $display("FAIL held_through_reset: cycle %0d q_level=%0d busy=%b step=%b required 0 0 0",
                 k, q_level, busy, step_option);
      end
    end
    btn_step = 4'b0;
    clk1();
    press(4'b0001, 2'b00);
    total++;
    if (q_level !== 3'd1) begin
      bad++;
      $display("FAIL repress_after_reset: q_level=%0d required 1", q_level);
    end
    flush_pulse();
  endtask

  task automatic test_single();
    wait_tick();
    clk1();
    press(4'b0100, 2'b00);
    total++;
    if (q_level !== 3'd1 || busy !== 1'b1 || step_option !== 4'b0) begin
      bad++;
      $display("FAIL single_enqueue: q=%0d busy=%b step=%b required 1 1 0000", q_level, busy, step_option);
    end
    wait_tick();
    total++;
    if (q_level !== 3'd1) begin
      bad++;
      $display("FAIL single_wait: q_level=%0d required 1", q_level);
    end
    clk1();
    total++;
    if (step_option !== 4'b0100 || q_level !== 3'd0 || hold_option !== 3'b0) begin
      bad++;
      $display("FAIL single_present: step=%b q=%0d hold=%b required 0100 0 000", step_option, q_level, hold_option);
    end
    for (int i = 0; i < 7; i++) begin
      clk1();
      total++;
      if (step_option !== 4'b0100) begin
        bad++;
        $display("FAIL single_hold_window: cycle %0d step=%b required 0100", i, step_option);
      end
    end
    clk1();
    total++;
    if (step_option !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_clear: step=%b busy=%b required 0000 0", step_option, busy);
    end
  endtask

  task automatic test_same_cycle();
    wait_tick();
    clk1();
    press(4'b0001, 2'b10);
    total++;
    if (q_level !== 3'd1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_enqueue: q=%0d ovf=%b required 1 1", q_level, overflow);
    end
    wait_tick();
    clk1();
    total++;
    if (hold_option !== 3'b010 || step_option !== 4'b0 || q_level !== 3'd0) begin
      bad++;
      $display("FAIL same_cycle_present: hold=%b step=%b q=%0d required 010 0000 0", hold_option, step_option, q_level);
    end
    flush_pulse();
    total++;
    if (overflow !== 1'b0 || hold_option !== 3'b0) begin
      bad++;
      $display("FAIL same_cycle_flush: ovf=%b hold=%b required 0 000", overflow, hold_option);
    end
  endtask

  task automatic test_queue_full();
    logic [3:0] exp;
    wait_tick();
    clk1();
    press(4'b0001, 2'b00);
    press(4'b0010, 2'b00);
    press(4'b0100, 2'b00);
    press(4'b1000, 2'b00);
    press(4'b0000, 2'b01);
    press(4'b0000, 2'b10);
    total++;
    if (q_level !== 3'd4 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL queue_full_fill: q=%0d ovf=%b required 4 1", q_level, overflow);
    end
    exp = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      clk1();
      total++;
      if (step_option !== exp || q_level !== 3'(3 - i)) begin
        bad++;
        $display("FAIL queue_full_order: slot %0d step=%b q=%0d required %b %0d", i, step_option, q_level, exp, 3 - i);
      end
      exp = exp << 1;
    end
    wait_tick();
    clk1();
    total++;
    if (step_option !== 4'b0 || hold_option !== 3'b0 || busy !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL queue_full_drain: step=%b hold=%b busy=%b ovf=%b required 0000 000 0 1",
               step_option, hold_option, busy, overflow);
    end
    flush_pulse();
  endtask

  task automatic test_full_tick();
    logic [3:0] exp;
    wait_tick();
    clk1();
    press(4'b0001, 2'b00);
    press(4'b0010, 2'b00);
    press(4'b0100, 2'b00);
    press(4'b1000, 2'b00);
    total++;
    if (q_level !== 3'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_tick_fill: q=%0d ovf=%b required 4 0", q_level, overflow);
    end
    wait_tick();
    press(4'b0000, 2'b01);
    total++;
    if (q_level !== 3'd4 || overflow !== 1'b0 || step_option !== 4'b0001) begin
      bad++;
      $display("FAIL full_tick_simul: q=%0d ovf=%b step=%b required 4 0 0001", q_level, overflow, step_option);
    end
    exp = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      clk1();
      total++;
      if (step_option !== exp) begin
        bad++;
        $display("FAIL full_tick_order: slot %0d step=%b required %b", i, step_option, exp);
      end
      exp = exp << 1;
    end
    wait_tick();
    clk1();
    total++;
    if (hold_option !== 3'b001 || step_option !== 4'b0 || q_level !== 3'd0) begin
      bad++;
      $display("FAIL full_tick_hold: hold=%b step=%b q=%0d required 001 0000 0", hold_option, step_option, q_level);
    end
  endtask

  task automatic test_flush();
    wait_tick();
    clk1();
    press(4'b1001, 2'b00);
    press(4'b0010, 2'b00);
    press(4'b0100, 2'b00);
    total++;
    if (q_level !== 3'd3 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL flush_fill: q=%0d ovf=%b required 3 1", q_level, overflow);
    end
    wait_tick();
    clk1();
    total++;
    if (step_option !== 4'b0001 || q_level !== 3'd2) begin
      bad++;
      $display("FAIL flush_pre: step=%b q=%0d required 0001 2", step_option, q_level);
    end
    flush    = 1'b1;
    btn_step = 4'b1000;
    clk1();
    flush    = 1'b0;
    btn_step = 4'b0;
    total++;
    if (step_option !== 4'b0 || hold_option !== 3'b0 || q_level !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: step=%b hold=%b q=%0d ovf=%b busy=%b required all zero",
               step_option, hold_option, q_level, overflow, busy);
    end
    wait_tick();
    total++;
    if (cyc % 8 != 0) begin
      bad++;
      $display("FAIL flush_phase: tick at cycle %0d mod 8 = %0d required 0", cyc, cyc % 8);
    end
  endtask

  task automatic test_mid_reset();
    wait_tick();
    clk1();
    press(4'b0001, 2'b00);
    press(4'b0010, 2'b00);
    wait_tick();
    clk1();
    reset_n = 1'b0;
    #1;
    total++;
    if ({tick, step_option, hold_option, q_level, overflow, busy} !== 13'b0) begin
      bad++;
      $display("FAIL mid_reset: got %b required all zero",
               {tick, step_option, hold_option, q_level, overflow, busy});
    end
    clk1();
    reset_n = 1'b1;
    repeat (10) clk1();
    total++;
    if (step_option !== 4'b0 || q_level !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_after: step=%b q=%0d busy=%b required 0000 0 0", step_option, q_level, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_queue_full();
    test_full_tick();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
